// File: rtl/program_loader.sv
// Byte-serializing program loader for the core's memory-load port; holds the core in reset while loading.
// Optional running word checksum is built only when LOADER_CHECKSUM_EN is defined.
module program_loader #(
  parameter int WIDTH     = 32,
  parameter int MEM_DEPTH = 16384,
  parameter int BASE_ADDR = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             memEn,
  output logic [WIDTH-1:0] memAddr,
  output logic [WIDTH-1:0] memData,
  output logic             core_reset,
  output logic             busy,
  output logic             overflow,
  output logic [WIDTH-1:0] byte_count,
  output logic [WIDTH-1:0] checksum
);

  // state     | meaning
  // IDLE      | core held in reset, waiting for start
  // WAIT_WORD | session open, stream ready for the next word
  // WRITE     | emitting the four bytes of the captured word
  // RUN       | load finished, core released from reset
  typedef enum logic [1:0] {IDLE, WAIT_WORD, WRITE, RUN} state_t;

  localparam logic [WIDTH-1:0] BASE  = WIDTH'(BASE_ADDR);
  localparam logic [WIDTH-1:0] LIMIT = WIDTH'(MEM_DEPTH);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] addr;
  logic [WIDTH-1:0] word;
  logic             last;
  logic [1:0]       idx;
  logic             accept;
  logic             session_start;
  logic             in_window;

  assign accept        = (state == WAIT_WORD) && in_valid;
  assign session_start = start && ((state == IDLE) || (state == RUN));
  // addr is a plain counter; once past the window every later byte is dropped
  assign in_window     = addr < LIMIT;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (start) state_nxt = WAIT_WORD;
      WAIT_WORD: if (accept) state_nxt = WRITE;
      WRITE:     if (idx == 2'd3) state_nxt = last ? RUN : WAIT_WORD;
      RUN:       if (start) state_nxt = WAIT_WORD;
      default:   state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready   = 1'b0;
    busy       = 1'b0;
    core_reset = 1'b1;
    memEn      = 1'b0;
    memAddr    = '0;
    memData    = '0;
    case (state)
      WAIT_WORD: begin
        in_ready = 1'b1;
        busy     = 1'b1;
      end
      WRITE: begin
        busy    = 1'b1;
        memEn   = in_window;
        memAddr = addr;
        memData = {{(WIDTH-8){1'b0}}, word[{idx, 3'b000} +: 8]};
      end
      RUN:     core_reset = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      addr       <= '0;
      word       <= '0;
      last       <= 1'b0;
      idx        <= '0;
      byte_count <= '0;
      overflow   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (session_start) begin
        addr       <= BASE;
        byte_count <= '0;
        overflow   <= 1'b0;
      end
      if (accept) begin
        word <= in_data;
        last <= in_last;
        idx  <= '0;
      end
      if (state == WRITE) begin
        idx  <= idx + 1'b1;
        addr <= addr + 1'b1;
        if (in_window) byte_count <= byte_count + 1'b1;
        else           overflow   <= 1'b1;
      end
    end
  end

`ifdef LOADER_CHECKSUM_EN
  // sums every accepted word, including words whose bytes fall outside the window
  always_ff @(posedge clock) begin
    if (reset)              checksum <= '0;
    else if (session_start) checksum <= '0;
    else if (accept)        checksum <= checksum + in_data;
  end
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: two instances (base 0 and base near the top of memory) share stimulus
// and are checked against a per-session byte-write model built from the load rules.
module tb_program_loader;

  localparam int W      = 32;
  localparam int DEPTH  = 16384;
  localparam int BASE_L = 0;
  localparam int BASE_H = 16380;

  logic clock = 1'b0;
  logic reset, start, in_valid, in_last;
  logic [W-1:0] in_data;

  logic         rdy_l, en_l, cr_l, busy_l, ovf_l;
  logic [W-1:0] addr_l, data_l, cnt_l, sum_l;
  logic         rdy_h, en_h, cr_h, busy_h, ovf_h;
  logic [W-1:0] addr_h, data_h, cnt_h, sum_h;

  int n_asserts = 0;
  int n_fail    = 0;
  logic [31:0] wq[$];

  always #5 clock = ~clock;

  program_loader #(.WIDTH(W), .MEM_DEPTH(DEPTH), .BASE_ADDR(BASE_L)) dut_lo (
    .clock(clock), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(rdy_l),
    .in_data(in_data), .in_last(in_last), .memEn(en_l), .memAddr(addr_l), .memData(data_l),
    .core_reset(cr_l), .busy(busy_l), .overflow(ovf_l), .byte_count(cnt_l), .checksum(sum_l));

  program_loader #(.WIDTH(W), .MEM_DEPTH(DEPTH), .BASE_ADDR(BASE_H)) dut_hi (
    .clock(clock), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(rdy_h),
    .in_data(in_data), .in_last(in_last), .memEn(en_h), .memAddr(addr_h), .memData(data_h),
    .core_reset(cr_h), .busy(busy_h), .overflow(ovf_h), .byte_count(cnt_h), .checksum(sum_h));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // handshake/status outputs identical on both instances
  task automatic chk_ctl(input string tag, input logic rdy, input logic cr, input logic bsy);
    chk({tag, "_ready_lo"}, {31'd0, rdy_l}, {31'd0, rdy});
    chk({tag, "_ready_hi"}, {31'd0, rdy_h}, {31'd0, rdy});
    chk({tag, "_corerst_lo"}, {31'd0, cr_l}, {31'd0, cr});
    chk({tag, "_corerst_hi"}, {31'd0, cr_h}, {31'd0, cr});
    chk({tag, "_busy_lo"}, {31'd0, busy_l}, {31'd0, bsy});
    chk({tag, "_busy_hi"}, {31'd0, busy_h}, {31'd0, bsy});
  endtask

  task automatic chk_stat(input string tag, input int c0, input bit o0, input int c1, input bit o1,
                          input logic [31:0] s);
    chk({tag, "_count_lo"}, cnt_l, c0);
    chk({tag, "_count_hi"}, cnt_h, c1);
    chk({tag, "_ovf_lo"}, {31'd0, ovf_l}, {31'd0, o0});
    chk({tag, "_ovf_hi"}, {31'd0, ovf_h}, {31'd0, o1});
    chk({tag, "_sum_lo"}, sum_l, s);
    chk({tag, "_sum_hi"}, sum_h, s);
  endtask

  // Runs one full session with the words in wq. Entered and left at a negedge with start low,
  // DUT in IDLE or RUN. b2b keeps in_valid high with the next word through the WRITE cycles.
  task automatic do_session(input int gap_max, input bit b2b);
    int n = wq.size();
    int c0 = 0, c1 = 0;
    bit o0 = 0, o1 = 0;
    logic [31:0] s = 0;
    logic [31:0] w;
    int a0, a1;
    logic [7:0] b;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    chk_ctl("sess_open", 1'b1, 1'b1, 1'b1);
    chk_stat("sess_open", 0, 0, 0, 0, 0);
    chk("sess_open_en", {31'd0, en_l | en_h}, 0);
    for (int k = 0; k < n; k++) begin
      if (!b2b) begin
        int g = $urandom_range(0, gap_max);
        in_valid = 1'b0;
        for (int i = 0; i < g; i++) begin
          @(negedge clock);
          chk("gap_ready", {31'd0, rdy_l & rdy_h}, 1);
          chk("gap_en", {31'd0, en_l | en_h}, 0);
        end
      end
      w = wq[k];
      in_valid = 1'b1;
      in_data  = w;
      in_last  = (k == n - 1);
      chk("accept_ready", {31'd0, rdy_l & rdy_h}, 1);
      s = s + w;
      for (int j = 0; j < 4; j++) begin
        @(negedge clock);
        if (b2b && (k + 1 < n)) begin
          in_valid = 1'b1;
          in_data  = wq[k+1];
          in_last  = (k + 1 == n - 1);
        end else begin
          in_valid = 1'($urandom_range(0, 1));
          in_data  = $urandom;
          in_last  = 1'($urandom_range(0, 1));
        end
        start = ($urandom_range(0, 3) == 0);
        a0 = BASE_L + 4 * k + j;
        a1 = BASE_H + 4 * k + j;
        b  = w[8*j +: 8];
        chk_ctl("write", 1'b0, 1'b1, 1'b1);
        chk("write_en_lo", {31'd0, en_l}, {31'd0, a0 < DEPTH});
        chk("write_en_hi", {31'd0, en_h}, {31'd0, a1 < DEPTH});
        chk("write_addr_lo", addr_l, a0);
        chk("write_addr_hi", addr_h, a1);
        chk("write_data_lo", data_l, {24'd0, b});
        chk("write_data_hi", data_h, {24'd0, b});
        if (a0 < DEPTH) c0++; else o0 = 1;
        if (a1 < DEPTH) c1++; else o1 = 1;
      end
      @(negedge clock);
      start = 1'b0;
      if (!(b2b && (k + 1 < n))) in_valid = 1'b0;
    end
`ifndef LOADER_CHECKSUM_EN
    s = 0;
`endif
    chk_ctl("run", 1'b0, 1'b0, 1'b0);
    chk("run_en", {31'd0, en_l | en_h}, 0);
    chk_stat("run", c0, o0, c1, o1, s);
    // stream activity in RUN must be ignored
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_data  = $urandom;
      @(negedge clock);
      chk_ctl("run_idle", 1'b0, 1'b0, 1'b0);
      chk("run_idle_count_lo", cnt_l, c0);
    end
    in_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0;
    repeat (3) @(negedge clock);
    chk_ctl("rst", 1'b0, 1'b1, 1'b0);
    chk_stat("rst", 0, 0, 0, 0, 0);
    chk("rst_en", {31'd0, en_l | en_h}, 0);
    chk("rst_addr", addr_l | addr_h, 0);
    chk("rst_data", data_l | data_h, 0);

    reset = 1'b0;
    in_valid = 1'b1; in_data = 32'hCAFEF00D;
    repeat (2) begin
      @(negedge clock);
      chk_ctl("idle_valid", 1'b0, 1'b1, 1'b0);
    end
    in_valid = 1'b0;

    wq = {}; wq.push_back(32'h00000013);
    do_session(0, 1'b0);
    wq = {}; wq.push_back(32'hDEADBEEF); wq.push_back(32'h12345678);
    do_session(0, 1'b1);
    wq = {}; wq.push_back(32'h11223344); wq.push_back(32'h55667788);
    do_session(2, 1'b0);
    wq = {}; wq.push_back(32'h00000001); wq.push_back(32'h00000002); wq.push_back(32'hFFFFFFFF);
    do_session(1, 1'b0);

    // reset during the second WRITE cycle, together with a start that must lose
    start = 1'b1; @(negedge clock); start = 1'b0;
    in_valid = 1'b1; in_data = 32'hA5A5A5A5; in_last = 1'b1;
    @(negedge clock);
    in_valid = 1'b0;
    @(negedge clock);
    chk("mid_en", {31'd0, en_l}, 1);
    chk("mid_addr", addr_l, BASE_L + 1);
    reset = 1'b1; start = 1'b1;
    @(negedge clock);
    reset = 1'b0; start = 1'b0;
    chk_ctl("midrst", 1'b0, 1'b1, 1'b0);
    chk_stat("midrst", 0, 0, 0, 0, 0);
    chk("midrst_en", {31'd0, en_l | en_h}, 0);
    @(negedge clock);
    chk_ctl("midrst_idle", 1'b0, 1'b1, 1'b0);
    wq = {}; wq.push_back(32'h0BADC0DE);
    do_session(1, 1'b0);

    for (int r = 0; r < 20; r++) begin
      int n = $urandom_range(1, 6);
      wq = {};
      for (int i = 0; i < n; i++) wq.push_back($urandom);
      do_session(3, 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
